adder_chunk_sequencer: RTL and testbench

- Upstream/downstream companion to the team's 8-bit combinational prefix adder (module `adder`: inputs a, b; output s; no carry-in, no carry-out).
- Performs WIDTH-bit additions with carry-in by streaming 8-bit chunks through one external `adder` instance, LSB chunk first.
- Drives the adder's a/b, consumes its s, and derives carry-out itself.
- Carry-in is realised as a second "+1" pass through the same adder. Operands enter and results leave on valid/ready handshakes.

---
 rtl/adder_chunk_sequencer.sv | 157 +++++++++++++++
 tb/tb_adder_chunk_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_chunk_sequencer.sv
// Streams W-bit additions with carry-in through an external 8-bit adder, one
// byte per pass, LSB chunk first; carry-in is applied as an extra "+1" pass.
module adder_chunk_sequencer #(
    parameter int NCHUNK = 4,
    localparam int W = 8 * NCHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    input  logic [7:0]   add_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic [1:0]   dbg_state
);

    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_INC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic [IDXW-1:0]   r_idx;
    logic [7:0]        r_tmp;
    logic              r_carry;
    logic              r_pend;
    logic              r_cout;

    logic              w_pass_c;
    logic              w_last;
    logic              w_store;
    logic              w_chunk_c;
    logic [IDXW+2:0]   w_base;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and a presented result is held
    // unchanged until it transfers.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign dbg_state = r_state;

    assign w_base = {r_idx, 3'b000};
    assign w_last = (r_idx == IDXW'(NCHUNK - 1));

    always_comb begin
        add_a = 8'h00;
        add_b = 8'h00;
        case (r_state)
            S_ADD: begin
                add_a = r_a[w_base +: 8];
                add_b = r_b[w_base +: 8];
            end
            S_INC: begin
                add_a = r_tmp;
                add_b = 8'h01;
            end
            default: begin
                add_a = 8'h00;
                add_b = 8'h00;
            end
        endcase
    end

    // Carry out of bit 7 recovered from the operand and sum MSBs alone.
    assign w_pass_c = (add_a[7] & add_b[7]) | ((add_a[7] ^ add_b[7]) & ~add_s[7]);

    // A chunk is finished on an ADD pass without pending carry, or on its INC pass.
    assign w_store   = ((r_state == S_ADD) && !r_carry) || (r_state == S_INC);
    assign w_chunk_c = (r_state == S_INC) ? (r_pend | w_pass_c) : w_pass_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_nxt = S_ADD;
            end
            S_ADD: begin
                if (r_carry)     w_state_nxt = S_INC;
                else if (w_last) w_state_nxt = S_DONE;
                else             w_state_nxt = S_ADD;
            end
            S_INC: begin
                w_state_nxt = w_last ? S_DONE : S_ADD;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_tmp   <= 8'h00;
            r_carry <= 1'b0;
            r_pend  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && in_valid) begin
                r_a     <= in_a;
                r_b     <= in_b;
                r_carry <= in_cin;
                r_idx   <= '0;
            end
            if ((r_state == S_ADD) && r_carry) begin
                r_tmp  <= add_s;
                r_pend <= w_pass_c;
            end
            if (w_store) begin
                r_sum[w_base +: 8] <= add_s;
                r_carry            <= w_chunk_c;
                if (w_last) begin
                    r_cout <= w_chunk_c;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // tmp came from a pass that overflowed, so tmp <= 8'hFE and +1 cannot carry.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == S_INC)) begin
            assert (!(r_pend && w_pass_c));
        end
    end

endmodule

// File: tb/tb_adder_chunk_sequencer.sv
// Directed bench for adder_chunk_sequencer: expected results and latencies are
// queued at issue time and checked by an independent output monitor.
module tb_adder_chunk_sequencer;

    localparam int NCHUNK = 4;
    localparam int W = 8 * NCHUNK;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic [7:0]   add_s;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic [1:0]   dbg_state;

    logic [W:0] exp_q[$];
    int         lat_q[$];
    int         acc_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic prev_ov = 1'b0;

    adder_chunk_sequencer #(.NCHUNK(NCHUNK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .dbg_state(dbg_state)
    );

    // Behavioural stand-in for the external 8-bit adder.
    assign add_s = add_a + add_b;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: latency on the rising edge of out_valid, data on the handshake.
    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && !prev_ov) begin
            if (lat_q.size() == 0) begin
                timeout_fail("unexpected_out_valid");
            end else begin
                int lat;
                int acc;
                lat = lat_q.pop_front();
                acc = acc_q.pop_front();
                check("latency", 64'(cyc - acc), 64'(lat));
            end
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                timeout_fail("unexpected_result");
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("out_sum", 64'(out_sum), 64'(e[W-1:0]));
                check("out_cout", 64'(out_cout), 64'(e[W]));
            end
        end
        prev_ov = out_valid && rst_n;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int lat, input logic [W-1:0] es, input logic ec, input bit track);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            timeout_fail("wait_in_ready");
            return;
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        if (track) begin
            exp_q.push_back({ec, es});
            lat_q.push_back(lat);
        end
        @(posedge clk);
        #1;
        if (track) acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid) timeout_fail("wait_out_valid");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);

        send(32'h12345678, 32'h9ABCDEF0, 1'b0, 6, 32'hACF13568, 1'b0, 1'b1);
        send(32'h000000FF, 32'h00000001, 1'b0, 5, 32'h00000100, 1'b0, 1'b1);
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 8, 32'h00000000, 1'b1, 1'b1);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 8, 32'hFFFFFFFF, 1'b1, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 4, 32'h00000000, 1'b1, 1'b1);
        send(32'h00000000, 32'h00000000, 1'b1, 5, 32'h00000001, 1'b0, 1'b1);

        // Backpressure with a competing request held on the input.
        send(32'h11111111, 32'h22222222, 1'b0, 4, 32'h33333333, 1'b0, 1'b1);
        out_ready = 1'b0;
        wait_valid();
        in_valid = 1'b1;
        in_a = 32'h0000FFFF;
        in_b = 32'h00000001;
        in_cin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_sum", 64'(out_sum), 64'h33333333);
            check("hold_out_cout", 64'(out_cout), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_sum", 64'(out_sum), 64'h33333333);
        exp_q.push_back({1'b0, 32'h00010001});
        lat_q.push_back(7);
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        check("accepted_after_hs", 64'(dbg_state), 64'd1);

        // Reset in the middle of an all-INC operation; its result must never appear.
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 8, 32'h00000000, 1'b1, 1'b0);
        begin
            int t;
            t = 0;
            while (dbg_state != 2'd2 && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (dbg_state != 2'd2) timeout_fail("wait_inc_state");
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum", 64'(out_sum), 64'd0);
        check("midrst_out_cout", 64'(out_cout), 64'd0);
        check("midrst_add_a", 64'(add_a), 64'd0);
        check("midrst_add_b", 64'(add_b), 64'd0);
        send(32'h12345678, 32'h9ABCDEF0, 1'b0, 6, 32'hACF13568, 1'b0, 1'b1);

        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 200) begin
                @(posedge clk);
                t++;
            end
            if (exp_q.size() != 0) timeout_fail("drain_results");
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
